// File: rtl/ssd_scheduler_pkg.sv
// Shared types, blank constants and the hex-to-segment map for the
// eight-digit display scheduler.
package ssd_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  localparam logic [7:0] AN_BLANK   = 8'hFF;
  localparam logic [7:0] CATH_BLANK = 8'hFF;

  // Returns {a,b,c,d,e,f,g,dp}, active-low, decimal point always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return {seg, 1'b1};
  endfunction

endpackage

// File: rtl/ssd_scheduler_hex_to_ssd.sv
// Combinational nibble to active-low cathode decoder.
module hex_to_ssd
  import ssd_scheduler_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] cath_o
);

  assign cath_o = hex_to_seg(nib_i);

endmodule

// File: rtl/ssd_scheduler.sv
// Two-requester arbiter and multiplexed scanner for an eight-digit
// seven-segment display; ownership only changes between frames.
module ssd_scheduler
  import ssd_scheduler_pkg::*;
#(
  parameter int unsigned DIGIT_CYC = 262144,
  parameter int unsigned BLANK_CYC = 1024,
  parameter int unsigned HOLD_MIN  = 8
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [7:0]  An,
  output logic [7:0]  Cath,
  output logic        frame_done
);

  localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYC - 1);
  localparam logic [23:0] DIGIT_LAST = 24'(DIGIT_CYC - 1);
  localparam logic [7:0]  HOLD_LIM   = 8'(HOLD_MIN);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] snap_q, snap_d;

  owner_e      arb_owner_s;
  logic [7:0]  arb_hold_s;
  logic        owner_req_s;
  logic        arb_now_s;
  logic [3:0]  nib_s;
  logic [7:0]  seg_s;

  assign owner_req_s = ((owner_q == OWN_A) && req_a) || ((owner_q == OWN_B) && req_b);

  // Frame-boundary arbitration: keep a requesting owner until its hold
  // expires, then hand over to B if A just expired so B cannot starve.
  always_comb begin
    arb_owner_s = OWN_NONE;
    arb_hold_s  = 8'd0;
    if (owner_req_s && (hold_q < HOLD_LIM)) begin
      arb_owner_s = owner_q;
      arb_hold_s  = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
    end else if ((owner_q == OWN_A) && req_b) begin
      arb_owner_s = OWN_B;
      arb_hold_s  = 8'd1;
    end else if (req_a) begin
      arb_owner_s = OWN_A;
      arb_hold_s  = 8'd1;
    end else if (req_b) begin
      arb_owner_s = OWN_B;
      arb_hold_s  = 8'd1;
    end else begin
      arb_owner_s = OWN_NONE;
      arb_hold_s  = 8'd0;
    end
  end

  // Next-state logic for the scan position, ownership and snapshot.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    snap_d    = snap_q;
    arb_now_s = 1'b0;
    case (state_q)
      ST_IDLE: arb_now_s = 1'b1;
      ST_BLANK: begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIGIT_LAST) begin
          if (idx_q == 3'd7) begin
            arb_now_s = 1'b1;
          end else begin
            state_d = ST_BLANK;
            idx_d   = idx_q + 3'd1;
            cnt_d   = 24'd0;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb_now_s) begin
      owner_d = arb_owner_s;
      hold_d  = arb_hold_s;
      idx_d   = 3'd0;
      cnt_d   = 24'd0;
      if (arb_owner_s == OWN_NONE) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_BLANK;
        snap_d  = (arb_owner_s == OWN_A) ? data_a : data_b;
      end
    end else begin
      owner_d = owner_q;
    end
  end

  // Decode from next-state values so the registered outputs line up with the state.
  assign nib_s = snap_d[{idx_d, 2'b00} +: 4];

  hex_to_ssd u_hex_to_ssd (
    .nib_i  (nib_s),
    .cath_o (seg_s)
  );

  // State and registered display/grant outputs.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      idx_q      <= 3'd0;
      cnt_q      <= 24'd0;
      hold_q     <= 8'd0;
      snap_q     <= 32'd0;
      An         <= AN_BLANK;
      Cath       <= CATH_BLANK;
      grant_a    <= 1'b0;
      grant_b    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      snap_q     <= snap_d;
      An         <= (state_d == ST_SHOW) ? ~(8'd1 << idx_d) : AN_BLANK;
      Cath       <= (state_d == ST_SHOW) ? seg_s : CATH_BLANK;
      grant_a    <= (owner_d == OWN_A);
      grant_b    <= (owner_d == OWN_B);
      frame_done <= (state_d == ST_SHOW) && (idx_d == 3'd7) && (cnt_d == DIGIT_LAST);
    end
  end

endmodule
